ssm2603_cfg_ctrl: RTL and testbench

- Power-up configuration sequencer for the SSM2603 audio codec that sits behind the i2s playback transmitter.
- After in_start, writes a fixed register table over a write-only I2C master, waits for VMID settling, then activates the codec.
- Then raises out_audio_en, which drives the transmitter's in_en. Playback can only start once the codec is configured.
- Sits at the top level between board reset/user control and the i2s block.

---
 rtl/ssm2603_cfg_ctrl_pkg.sv | 44 ++++
 rtl/ssm2603_cfg_ctrl_i2c_word_writer.sv | 168 ++++++++++++++++
 rtl/ssm2603_cfg_ctrl.sv | 135 +++++++++++++
 tb/tb_ssm2603_cfg_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ssm2603_cfg_ctrl_pkg.sv
// rtl/ssm2603_cfg_ctrl_pkg.sv - states, register table and index constants for the SSM2603 config sequencer
package ssm2603_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_WAIT_WR,
    ST_VMID,
    ST_DONE,
    ST_ERROR
  } cfg_state_e;

  typedef enum logic [2:0] {
    W_IDLE,
    W_START,
    W_BIT,
    W_STOP_A,
    W_STOP_B,
    W_STOP_C,
    W_FREE
  } wr_phase_e;

  localparam int NUM_WRITES = 11;

  localparam logic [3:0] IDX_LAST_PRE = 4'd8;
  localparam logic [3:0] IDX_ACTIVE   = 4'd9;
  localparam logic [3:0] IDX_LAST     = 4'd10;

  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h1A;
  localparam logic [7:0] ADDR_BYTE        = {DEV_ADDR_DEFAULT, 1'b0};

  // R15 reset first; R9 activate and final R6 only after VMID has settled
  localparam logic [6:0] REG_ADDR [NUM_WRITES] = '{
    7'd15, 7'd6, 7'd0, 7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd7, 7'd9, 7'd6
  };
  localparam logic [8:0] REG_DATA [NUM_WRITES] = '{
    9'h000, 9'h072, 9'h017, 9'h017, 9'h079, 9'h079, 9'h012, 9'h000, 9'h009, 9'h001, 9'h062
  };

  function automatic logic [7:0] addr_byte(input logic [6:0] dev);
    return {dev, 1'b0};
  endfunction

endpackage

// File: rtl/ssm2603_cfg_ctrl_i2c_word_writer.sv
// rtl/ssm2603_cfg_ctrl_i2c_word_writer.sv - write-only I2C master sending one 3-byte codec register write
module i2c_word_writer
  import ssm2603_cfg_pkg::*;
#(
  parameter int         CLK_DIV  = 184,
  parameter logic [6:0] DEV_ADDR = 7'h1A
) (
  input  logic        in_clk,
  input  logic        in_rst,
  input  logic        in_go,
  input  logic [15:0] in_word,
  input  logic        in_SDA,
  output logic        out_SCL,
  output logic        out_SDA_oe,
  output logic        out_done,
  output logic        out_ack_ok
);

  localparam int            DW       = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  wr_phase_e     phase_q, phase_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    qtr_q, qtr_d;
  logic [3:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [7:0]    sh_q, sh_d;
  logic [15:0]   word_q, word_d;
  logic [1:0]    sda_sync_q, sda_sync_d;
  logic          scl_q, scl_d;
  logic          oe_q, oe_d;
  logic          nack_q, nack_d;
  logic          done_q, done_d;
  logic          ack_ok_q, ack_ok_d;
  logic          tick;

  assign tick = (phase_q != W_IDLE) && (div_q == DIV_LAST);

  always_comb begin
    phase_d    = phase_q;
    qtr_d      = qtr_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    sh_d       = sh_q;
    word_d     = word_q;
    scl_d      = scl_q;
    oe_d       = oe_q;
    nack_d     = nack_q;
    ack_ok_d   = ack_ok_q;
    done_d     = 1'b0;
    sda_sync_d = {sda_sync_q[0], in_SDA};
    div_d      = (phase_q == W_IDLE || tick) ? '0 : div_q + 1'b1;

    case (phase_q)
      W_IDLE: begin
        if (in_go) begin
          phase_d = W_START;
          word_d  = in_word;
          sh_d    = addr_byte(DEV_ADDR);
          scl_d   = 1'b1;
          oe_d    = 1'b1;
          nack_d  = 1'b0;
          qtr_d   = 2'd0;
          bit_d   = 4'd0;
          byte_d  = 2'd0;
        end
      end
      W_START: begin
        if (tick) begin
          phase_d = W_BIT;
          scl_d   = 1'b0;
        end
      end
      W_BIT: begin
        // SDA moves one tick into the low phase so it never races the SCL edge
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          case (qtr_q)
            2'd0: oe_d  = (bit_q == 4'd8) ? 1'b0 : ~sh_q[7];
            2'd1: scl_d = 1'b1;
            2'd2: if (bit_q == 4'd8) nack_d = sda_sync_q[1];
            2'd3: begin
              scl_d = 1'b0;
              if (bit_q != 4'd8) begin
                bit_d = bit_q + 4'd1;
                sh_d  = {sh_q[6:0], 1'b0};
              end else if (nack_q || byte_q == 2'd2) begin
                phase_d = W_STOP_A;
              end else begin
                bit_d  = 4'd0;
                byte_d = byte_q + 2'd1;
                sh_d   = (byte_q == 2'd0) ? word_q[15:8] : word_q[7:0];
              end
            end
          endcase
        end
      end
      W_STOP_A: begin
        if (tick) begin
          phase_d = W_STOP_B;
          oe_d    = 1'b1;
        end
      end
      W_STOP_B: begin
        if (tick) begin
          phase_d = W_STOP_C;
          scl_d   = 1'b1;
        end
      end
      W_STOP_C: begin
        if (tick) begin
          phase_d = W_FREE;
          oe_d    = 1'b0;
          qtr_d   = 2'd0;
        end
      end
      W_FREE: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == 2'd3) begin
            phase_d  = W_IDLE;
            done_d   = 1'b1;
            ack_ok_d = ~nack_q;
          end
        end
      end
      default: phase_d = W_IDLE;
    endcase
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      phase_q    <= W_IDLE;
      div_q      <= '0;
      qtr_q      <= 2'd0;
      bit_q      <= 4'd0;
      byte_q     <= 2'd0;
      sh_q       <= 8'd0;
      word_q     <= 16'd0;
      sda_sync_q <= 2'b11;
      scl_q      <= 1'b1;
      oe_q       <= 1'b0;
      nack_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_ok_q   <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      div_q      <= div_d;
      qtr_q      <= qtr_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      sh_q       <= sh_d;
      word_q     <= word_d;
      sda_sync_q <= sda_sync_d;
      scl_q      <= scl_d;
      oe_q       <= oe_d;
      nack_q     <= nack_d;
      done_q     <= done_d;
      ack_ok_q   <= ack_ok_d;
    end
  end

  assign out_SCL    = scl_q;
  assign out_SDA_oe = oe_q;
  assign out_done   = done_q;
  assign out_ack_ok = ack_ok_q;

endmodule

// File: rtl/ssm2603_cfg_ctrl.sv
// rtl/ssm2603_cfg_ctrl.sv - SSM2603 power-up sequencer: register table, retries, VMID wait, audio enable
module ssm2603_cfg_ctrl
  import ssm2603_cfg_pkg::*;
#(
  parameter int         CLK_DIV   = 184,
  parameter logic [6:0] DEV_ADDR  = 7'h1A,
  parameter int         VMID_WAIT = 5529600,
  parameter int         MAX_RETRY = 3
) (
  input  logic       in_clk,
  input  logic       in_rst,
  input  logic       in_start,
  input  logic       in_SDA,
  output logic       out_SCL,
  output logic       out_SDA_oe,
  output logic       out_busy,
  output logic       out_done,
  output logic       out_error,
  output logic [3:0] out_err_reg,
  output logic       out_audio_en
);

  localparam int VW = $clog2(VMID_WAIT + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);

  cfg_state_e    state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [3:0]    err_reg_q, err_reg_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [VW-1:0] vmid_q, vmid_d;
  logic          start_prev_q, start_prev_d;
  logic          start_rise;
  logic          wr_go, wr_done, wr_ack_ok;
  logic [15:0]   wr_word;

  assign start_rise = in_start & ~start_prev_q;
  assign wr_word    = {REG_ADDR[idx_q], REG_DATA[idx_q]};

  i2c_word_writer #(
    .CLK_DIV  (CLK_DIV),
    .DEV_ADDR (DEV_ADDR)
  ) u_writer (
    .in_clk     (in_clk),
    .in_rst     (in_rst),
    .in_go      (wr_go),
    .in_word    (wr_word),
    .in_SDA     (in_SDA),
    .out_SCL    (out_SCL),
    .out_SDA_oe (out_SDA_oe),
    .out_done   (wr_done),
    .out_ack_ok (wr_ack_ok)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    err_reg_d    = err_reg_q;
    retry_d      = retry_q;
    vmid_d       = vmid_q;
    start_prev_d = in_start;
    wr_go        = 1'b0;

    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (start_rise) begin
          state_d   = ST_WRITE;
          idx_d     = 4'd0;
          retry_d   = '0;
          err_reg_d = 4'd0;
        end
      end
      ST_WRITE: begin
        wr_go   = 1'b1;
        state_d = ST_WAIT_WR;
      end
      ST_WAIT_WR: begin
        if (wr_done) begin
          if (wr_ack_ok) begin
            retry_d = '0;
            if (idx_q == IDX_LAST_PRE) begin
              state_d = ST_VMID;
            end else if (idx_q == IDX_LAST) begin
              state_d = ST_DONE;
            end else begin
              idx_d   = idx_q + 4'd1;
              state_d = ST_WRITE;
            end
          end else if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + 1'b1;
            state_d = ST_WRITE;
          end else begin
            err_reg_d = idx_q;
            state_d   = ST_ERROR;
          end
        end
      end
      ST_VMID: begin
        if (vmid_q == VW'(VMID_WAIT - 1)) begin
          vmid_d  = '0;
          idx_d   = IDX_ACTIVE;
          state_d = ST_WRITE;
        end else begin
          vmid_d = vmid_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= 4'd0;
      err_reg_q    <= 4'd0;
      retry_q      <= '0;
      vmid_q       <= '0;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      err_reg_q    <= err_reg_d;
      retry_q      <= retry_d;
      vmid_q       <= vmid_d;
      start_prev_q <= start_prev_d;
    end
  end

  assign out_busy     = (state_q == ST_WRITE) || (state_q == ST_WAIT_WR) || (state_q == ST_VMID);
  assign out_done     = (state_q == ST_DONE);
  assign out_error    = (state_q == ST_ERROR);
  assign out_err_reg  = err_reg_q;
  assign out_audio_en = (state_q == ST_DONE);

endmodule

// File: tb/tb_ssm2603_cfg_ctrl.sv
// tb/tb_ssm2603_cfg_ctrl.sv - directed bench with an I2C slave model for ssm2603_cfg_ctrl
module tb_ssm2603_cfg_ctrl;

  localparam int CLK_DIV   = 4;
  localparam int VMID_WAIT = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       sda_in;
  logic       scl, sda_oe, busy, done, error, audio_en;
  logic [3:0] err_reg;
  logic       slave_low = 1'b0;

  always #5 clk = ~clk;

  assign sda_in = ~sda_oe & ~slave_low;

  ssm2603_cfg_ctrl #(
    .CLK_DIV   (CLK_DIV),
    .DEV_ADDR  (7'h1A),
    .VMID_WAIT (VMID_WAIT),
    .MAX_RETRY (3)
  ) dut (
    .in_clk       (clk),
    .in_rst       (rst),
    .in_start     (start),
    .in_SDA       (sda_in),
    .out_SCL      (scl),
    .out_SDA_oe   (sda_oe),
    .out_busy     (busy),
    .out_done     (done),
    .out_error    (error),
    .out_err_reg  (err_reg),
    .out_audio_en (audio_en)
  );

  typedef struct {
    logic [31:0] rec;
    int          t_start;
    int          t_stop;
  } txn_t;

  txn_t txq[$];
  int   cyc = 0;
  int   n_starts = 0;
  int   viol = 0;
  int   audio_rise = 0;
  int   bitcnt = 0;
  int   bytecnt = 0;
  int   nack_mode = 0;
  int   nack_base = 0;
  int   n_pass = 0;
  int   n_total = 0;

  // Hand-computed {addr,data[8]}, data[7:0] pairs for table indices 0..10
  logic [15:0] exp_pair [11] = '{
    16'h1E00, 16'h0C72, 16'h0017, 16'h0217, 16'h0479, 16'h0679,
    16'h0812, 16'h0A00, 16'h0E09, 16'h1201, 16'h0C62
  };

  function automatic logic [31:0] full_rec(input int i);
    return {8'd3, 8'h34, exp_pair[i]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Slave model and bus monitor, sampled on the falling clock edge
  initial begin : monitor
    logic       p_scl, p_sda, p_audio, c_scl, c_sda, in_txn, nack;
    logic [7:0] shreg;
    txn_t       cur;
    int         tix;
    p_scl = 1'b1; p_sda = 1'b1; p_audio = 1'b0; in_txn = 1'b0; shreg = 8'd0;
    cur.rec = 32'd0; cur.t_start = 0; cur.t_stop = 0;
    forever begin
      @(negedge clk);
      cyc++;
      c_scl = scl;
      c_sda = sda_in;
      if (rst) begin
        in_txn = 1'b0; slave_low = 1'b0; bitcnt = 0; bytecnt = 0;
      end else if (p_scl && c_scl && p_sda && !c_sda) begin
        if (in_txn) viol++;
        in_txn = 1'b1; bitcnt = 0; bytecnt = 0; n_starts++;
        cur.rec = 32'd0; cur.t_start = cyc;
      end else if (p_scl && c_scl && !p_sda && c_sda) begin
        if (!in_txn || bitcnt != 1) viol++;
        if (in_txn) begin
          cur.t_stop = cyc;
          txq.push_back(cur);
        end
        in_txn = 1'b0;
      end else if (in_txn && !p_scl && c_scl) begin
        if (bitcnt < 8) shreg = {shreg[6:0], c_sda};
        bitcnt++;
      end else if (in_txn && p_scl && !c_scl) begin
        if (bitcnt == 8) begin
          cur.rec[23:0]  = {cur.rec[15:0], shreg};
          cur.rec[31:24] = cur.rec[31:24] + 8'd1;
          tix  = n_starts - 1 - nack_base;
          nack = (nack_mode == 1 && bytecnt == 2 && tix == 3) ||
                 (nack_mode == 2 && bytecnt == 0 && tix >= 5);
          slave_low = ~nack;
        end else if (bitcnt == 9) begin
          slave_low = 1'b0; bitcnt = 0; bytecnt++;
        end
      end
      if (audio_en && !p_audio) audio_rise = cyc;
      p_audio = audio_en;
      p_scl   = c_scl;
      p_sda   = ~sda_oe & ~slave_low;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int n;
    n = 0;
    while (!(done || error) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_finished"}, 32'(done | error), 32'd1);
  endtask

  initial begin : stim
    int base, n;
    @(negedge clk);
    chk("rst_scl", 32'(scl), 32'd1);
    chk("rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_err_reg", 32'(err_reg), 32'd0);
    chk("rst_audio_en", 32'(audio_en), 32'd0);
    rst = 1'b0;

    // Nominal all-ACK run, with stray start pulses while busy
    base = txq.size(); nack_base = n_starts; nack_mode = 0;
    pulse_start();
    repeat (700) @(negedge clk);
    chk("nom_busy", 32'(busy), 32'd1);
    pulse_start();
    repeat (2000) @(negedge clk);
    pulse_start();
    wait_end("nom");
    chk("nom_count", 32'(txq.size() - base), 32'd11);
    if (txq.size() - base == 11) begin
      for (int i = 0; i < 11; i++) chk($sformatf("nom_w%0d", i), txq[base + i].rec, full_rec(i));
      chk("nom_vmid_gap", 32'(txq[base + 9].t_start - txq[base + 8].t_stop >= VMID_WAIT), 32'd1);
      chk("nom_audio_after_stop", 32'(audio_rise > txq[base + 10].t_stop), 32'd1);
    end
    chk("nom_done", 32'(done), 32'd1);
    chk("nom_busy_low", 32'(busy), 32'd0);
    chk("nom_audio_en", 32'(audio_en), 32'd1);
    chk("nom_error", 32'(error), 32'd0);

    // Single NACK on the data byte of index 3
    do_reset();
    base = txq.size(); nack_base = n_starts; nack_mode = 1;
    pulse_start();
    wait_end("nack1");
    chk("nack1_count", 32'(txq.size() - base), 32'd12);
    if (txq.size() - base == 12) begin
      chk("nack1_failed_w3", txq[base + 3].rec, full_rec(3));
      chk("nack1_resend_w3", txq[base + 4].rec, full_rec(3));
      chk("nack1_last", txq[base + 11].rec, full_rec(10));
    end
    chk("nack1_error", 32'(error), 32'd0);
    chk("nack1_done", 32'(done), 32'd1);

    // Persistent address NACK from index 5
    do_reset();
    base = txq.size(); nack_base = n_starts; nack_mode = 2;
    pulse_start();
    wait_end("nackp");
    chk("nackp_count", 32'(txq.size() - base), 32'd9);
    if (txq.size() - base == 9)
      for (int i = 5; i < 9; i++) chk($sformatf("nackp_try%0d", i - 4), txq[base + i].rec, 32'h0100_0034);
    chk("nackp_error", 32'(error), 32'd1);
    chk("nackp_err_reg", 32'(err_reg), 32'd5);
    chk("nackp_audio_en", 32'(audio_en), 32'd0);
    chk("nackp_scl", 32'(scl), 32'd1);
    chk("nackp_sda_oe", 32'(sda_oe), 32'd0);
    chk("nackp_busy", 32'(busy), 32'd0);

    // Restart from ERROR with an all-ACK slave
    base = txq.size(); nack_base = n_starts; nack_mode = 0;
    pulse_start();
    wait_end("rest");
    chk("rest_count", 32'(txq.size() - base), 32'd11);
    if (txq.size() - base == 11) begin
      chk("rest_first", txq[base].rec, full_rec(0));
      chk("rest_last", txq[base + 10].rec, full_rec(10));
    end
    chk("rest_error", 32'(error), 32'd0);
    chk("rest_done", 32'(done), 32'd1);

    // Asynchronous reset mid-byte during index 2 while SCL is low and SDA driven
    do_reset();
    nack_base = n_starts;
    pulse_start();
    n = 0;
    while (!(n_starts - nack_base == 3 && bytecnt == 1 && bitcnt == 3 && !scl && sda_oe) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reached", 32'(n < 5000), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_scl", 32'(scl), 32'd1);
    chk("mid_sda_oe", 32'(sda_oe), 32'd0);
    chk("mid_audio_en", 32'(audio_en), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    base = txq.size();
    pulse_start();
    n = 0;
    while (txq.size() == base && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("mid_restart_first", (txq.size() > base) ? txq[base].rec : 32'd0, full_rec(0));

    chk("sda_stable_scl_high", 32'(viol), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
